// File: rtl/dm_load_unit.sv
// dm_load_unit: MEM-stage load interface. Issues one word read per load, waits for
// read data (or gives up after TIMEOUT), then presents the extended result under valid/take.
`ifndef DM_LB
`define DM_LB  4'd1
`define DM_LH  4'd2
`define DM_LW  4'd3
`define DM_LBU 4'd4
`define DM_LHU 4'd5
`endif

module dm_load_unit #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iReq,
  output logic              oReady,
  input  logic [31:0]       iAddr,
  input  logic [3:0]        ictrl,
  input  logic              iFlush,
  output logic              oMemReq,
  output logic [ADDR_W-1:0] oMemAddr,
  input  logic              iMemAck,
  input  logic              iMemRValid,
  input  logic [31:0]       iMemRData,
  output logic              oValid,
  input  logic              iTake,
  output logic [31:0]       oData,
  output logic              oAdEL,
  output logic              oBusErr,
  output logic              oBusy
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, RESP} state_t;
  state_t state, state_n;

  logic [CW-1:0] cnt;
  logic [1:0]    lo;
  logic [3:0]    kind;
  logic          is_load, aligned, accept, tmo;

  always_comb begin
    is_load = 1'b0;
    aligned = 1'b0;
    case (ictrl)
      `DM_LW:          begin is_load = 1'b1; aligned = (iAddr[1:0] == 2'b00); end
      `DM_LH, `DM_LHU: begin is_load = 1'b1; aligned = !iAddr[0]; end
      `DM_LB, `DM_LBU: begin is_load = 1'b1; aligned = 1'b1; end
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && iReq && is_load && !iFlush;
  assign tmo    = (cnt == CW'(TIMEOUT));

  function automatic logic [31:0] extract(input logic [3:0] k, input logic [1:0] a,
                                          input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (k)
      `DM_LB:  extract = {{24{b[7]}}, b};
      `DM_LBU: extract = {24'd0, b};
      `DM_LH:  extract = {{16{h[15]}}, h};
      `DM_LHU: extract = {16'd0, h};
      default: extract = w;
    endcase
  endfunction

  // Flush outranks every other event; an acked-but-flushed read still has to drain.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (accept) state_n = aligned ? REQ : RESP;
      REQ:   if (iFlush) state_n = iMemAck ? DRAIN : IDLE;
             else if (iMemAck) state_n = WAIT;
      WAIT:  if (iFlush) state_n = (iMemRValid || tmo) ? IDLE : DRAIN;
             else if (iMemRValid || tmo) state_n = RESP;
      DRAIN: if (iMemRValid || tmo) state_n = IDLE;
      RESP:  if (iFlush || iTake) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lo       <= '0;
      kind     <= '0;
      oMemAddr <= '0;
      oData    <= '0;
      oAdEL    <= 1'b0;
      oBusErr  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (accept) begin
          oMemAddr <= iAddr[ADDR_W+1:2];
          lo       <= iAddr[1:0];
          kind     <= ictrl;
          oAdEL    <= !aligned;
        end
        REQ: cnt <= '0;
        WAIT: begin
          if (!tmo) cnt <= cnt + 1'b1;
          if (state_n == RESP) begin
            if (iMemRValid) oData   <= extract(kind, lo, iMemRData);
            else            oBusErr <= 1'b1;
          end
        end
        DRAIN: if (!tmo) cnt <= cnt + 1'b1;
        RESP: if (state_n == IDLE) begin
          oData   <= '0;
          oAdEL   <= 1'b0;
          oBusErr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign oReady  = (state == IDLE);
  assign oBusy   = (state != IDLE);
  assign oMemReq = (state == REQ);
  assign oValid  = (state == RESP);
endmodule

// File: tb/tb_dm_load_unit.sv
// Bench for dm_load_unit: vector table, randomized loads against an arithmetic model,
// and hand sequences for flush, timeout, hold and asynchronous reset.
`timescale 1ns/1ps
`ifndef DM_LB
`define DM_LB  4'd1
`define DM_LH  4'd2
`define DM_LW  4'd3
`define DM_LBU 4'd4
`define DM_LHU 4'd5
`endif

module tb_dm_load_unit;
  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              iReq = 1'b0, iFlush = 1'b0, iTake = 1'b0;
  logic [31:0]       iAddr = '0, iMemRData = '0;
  logic [3:0]        ictrl = '0;
  logic              iMemAck = 1'b0, iMemRValid = 1'b0;
  logic              oReady, oMemReq, oValid, oAdEL, oBusErr, oBusy;
  logic [ADDR_W-1:0] oMemAddr;
  logic [31:0]       oData;

  dm_load_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .iReq(iReq), .oReady(oReady), .iAddr(iAddr), .ictrl(ictrl),
    .iFlush(iFlush), .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemAck(iMemAck),
    .iMemRValid(iMemRValid), .iMemRData(iMemRData), .oValid(oValid), .iTake(iTake),
    .oData(oData), .oAdEL(oAdEL), .oBusErr(oBusErr), .oBusy(oBusy));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit auto_mem = 1'b1;
  int ack_dly = 0, rv_dly = 0, req_cnt = 0, rv_cnt = -1;
  logic [31:0] mem_word = '0;

  typedef struct {
    logic [3:0]  k;
    logic [31:0] a, w;
    int          ackd, rvd;
    logic [31:0] ed;
    logic        eadel, eberr;
    int          elat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle; memory responder acts at the falling edge. rv_dly<0 means never answer.
  task automatic step();
    @(negedge clk);
    iMemAck    = 1'b0;
    iMemRValid = 1'b0;
    iMemRData  = $urandom;
    if (auto_mem) begin
      if (rv_cnt == 0) begin iMemRValid = 1'b1; iMemRData = mem_word; end
      if (rv_cnt >= 0) rv_cnt--;
      if (oMemReq) begin
        if (req_cnt == ack_dly) begin iMemAck = 1'b1; rv_cnt = rv_dly; req_cnt = 0; end
        else req_cnt++;
      end else req_cnt = 0;
    end
  endtask

  // Reference: {adel, data} from the load-kind rules with plain arithmetic.
  function automatic logic [32:0] ref_load(input logic [3:0] k, input logic [31:0] a,
                                           input logic [31:0] w);
    longint v;
    int     off;
    off = int'(a % 4);
    case (k)
      `DM_LW: return (off != 0) ? {1'b1, 32'h0} : {1'b0, w};
      `DM_LH, `DM_LHU: begin
        if (off % 2 != 0) return {1'b1, 32'h0};
        v = (longint'(w) >> (8 * off)) % 65536;
        if (k == `DM_LH && v >= 32768) v = v - 65536;
        return {1'b0, 32'(v)};
      end
      default: begin
        v = (longint'(w) >> (8 * off)) % 256;
        if (k == `DM_LB && v >= 128) v = v - 256;
        return {1'b0, 32'(v)};
      end
    endcase
  endfunction

  task automatic run_load(input logic [3:0] k, input logic [31:0] a, input logic [31:0] w,
                          input int ackd, input int rvd,
                          output logic [31:0] d, output logic adel, output logic berr,
                          output int lat, output bit saw_req, output bit addr_ok,
                          output bit idle_ok);
    mem_word = w; ack_dly = ackd; rv_dly = rvd; rv_cnt = -1; req_cnt = 0;
    iReq = 1'b1; iAddr = a; ictrl = k;
    step();
    iReq = 1'b0; ictrl = 4'h0; iAddr = $urandom;
    lat = 1; saw_req = 1'b0; addr_ok = 1'b1;
    while (!oValid && lat < 64) begin
      if (oMemReq) begin
        saw_req = 1'b1;
        if (oMemAddr !== ADDR_W'(a >> 2)) addr_ok = 1'b0;
      end
      if (oReady !== 1'b0) addr_ok = 1'b0;
      step();
      lat++;
    end
    d = oData; adel = oAdEL; berr = oBusErr;
    iTake = 1'b1;
    step();
    iTake = 1'b0;
    idle_ok = oReady && !oBusy && !oValid && !oMemReq && oData == 0 && !oAdEL && !oBusErr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    logic [3:0]  kinds[5];
    logic [31:0] d;
    logic        adel, berr;
    int          lat, n;
    bit          saw, aok, iok;

    tbl[0]  = '{`DM_LB,  32'h1003, 32'h80FF1234, 0,  0, 32'hFFFFFF80, 1'b0, 1'b0, 3};
    tbl[1]  = '{`DM_LBU, 32'h1003, 32'h80FF1234, 0,  0, 32'h00000080, 1'b0, 1'b0, 3};
    tbl[2]  = '{`DM_LH,  32'h1002, 32'h80017FFF, 3,  4, 32'hFFFF8001, 1'b0, 1'b0, 10};
    tbl[3]  = '{`DM_LHU, 32'h1002, 32'h80017FFF, 3,  4, 32'h00008001, 1'b0, 1'b0, 10};
    tbl[4]  = '{`DM_LW,  32'h1000, 32'h80017FFF, 3,  4, 32'h80017FFF, 1'b0, 1'b0, 10};
    tbl[5]  = '{`DM_LW,  32'h1002, 32'h80017FFF, 0,  0, 32'h0,        1'b1, 1'b0, 1};
    tbl[6]  = '{`DM_LH,  32'h1001, 32'h80017FFF, 0,  0, 32'h0,        1'b1, 1'b0, 1};
    tbl[7]  = '{`DM_LB,  32'h1001, 32'h80FF1234, 1,  0, 32'h00000012, 1'b0, 1'b0, 4};
    tbl[8]  = '{`DM_LBU, 32'h0002, 32'h80FF1234, 1,  2, 32'h000000FF, 1'b0, 1'b0, 6};
    tbl[9]  = '{`DM_LH,  32'h0000, 32'h00007FFF, 0,  1, 32'h00007FFF, 1'b0, 1'b0, 4};
    tbl[10] = '{`DM_LW,  32'h0FFC, 32'h12345678, 0, -1, 32'h0,        1'b0, 1'b1, 7};
    tbl[11] = '{`DM_LHU, 32'h1003, 32'h12345678, 0,  0, 32'h0,        1'b1, 1'b0, 1};
    tbl[12] = '{`DM_LBU, 32'h0005, 32'h12345678, 2, -1, 32'h0,        1'b0, 1'b1, 9};
    kinds = '{`DM_LB, `DM_LH, `DM_LW, `DM_LBU, `DM_LHU};

    // Reset values
    step(); step();
    chk("reset_flags", {26'd0, oReady, oBusy, oMemReq, oValid, oAdEL, oBusErr}, 32'h20);
    chk("reset_data", oData, 32'h0);
    chk("reset_addr", 32'(oMemAddr), 32'h0);
    rst_n = 1'b1;
    step();

    // Table vectors, issued back to back
    for (int i = 0; i < 13; i++) begin
      run_load(tbl[i].k, tbl[i].a, tbl[i].w, tbl[i].ackd, tbl[i].rvd, d, adel, berr, lat, saw, aok, iok);
      chk($sformatf("v%0d_data", i), d, tbl[i].ed);
      chk($sformatf("v%0d_adel", i), adel, tbl[i].eadel);
      chk($sformatf("v%0d_berr", i), berr, tbl[i].eberr);
      chk($sformatf("v%0d_lat", i), lat, tbl[i].elat);
      chk($sformatf("v%0d_memreq", i), saw, !tbl[i].eadel);
      chk($sformatf("v%0d_addr_busy", i), aok, 1'b1);
      chk($sformatf("v%0d_idle_after_take", i), iok, 1'b1);
    end

    // Randomized loads against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [3:0]  k;
      logic [31:0] a, w;
      logic [32:0] exp;
      int          ackd, rvd, elat;
      k    = kinds[$urandom_range(0, 4)];
      a    = $urandom;
      w    = $urandom;
      ackd = $urandom_range(0, 3);
      rvd  = $urandom_range(0, 5);
      if (rvd == 5) rvd = -1;
      exp  = ref_load(k, a, w);
      if (exp[32])      elat = 1;
      else if (rvd < 0) elat = 2 + ackd + TIMEOUT + 1;
      else              elat = 3 + ackd + rvd;
      run_load(k, a, w, ackd, rvd, d, adel, berr, lat, saw, aok, iok);
      chk($sformatf("r%0d_data", i), d, (rvd < 0 && !exp[32]) ? 32'h0 : exp[31:0]);
      chk($sformatf("r%0d_adel", i), adel, exp[32]);
      chk($sformatf("r%0d_berr", i), berr, !exp[32] && rvd < 0);
      chk($sformatf("r%0d_lat", i), lat, elat);
      chk($sformatf("r%0d_addr_busy", i), aok, 1'b1);
      chk($sformatf("r%0d_idle", i), iok, 1'b1);
    end

    // Non-load control code and flush in IDLE: no acceptance
    iReq = 1'b1; ictrl = 4'hF; iAddr = 32'h100;
    step();
    chk("nonload_ignored", {oReady, oBusy, oMemReq}, 3'b100);
    ictrl = `DM_LW; iFlush = 1'b1;
    step();
    chk("flush_idle_no_accept", {oReady, oBusy, oMemReq}, 3'b100);
    iReq = 1'b0; iFlush = 1'b0;

    // Flush in WAIT, data two cycles later: drained, never valid
    auto_mem = 1'b0;
    iReq = 1'b1; ictrl = `DM_LW; iAddr = 32'h2000;
    step(); iReq = 1'b0;
    iMemAck = 1'b1;
    step(); iFlush = 1'b1;
    step(); iFlush = 1'b0;
    chk("drain_busy", {oBusy, oReady, oValid, oMemReq}, 4'b1000);
    step();
    iMemRValid = 1'b1; iMemRData = 32'hDEADBEEF;
    step();
    chk("drain_to_idle", {oReady, oValid}, 2'b10);
    step();
    chk("drain_no_valid", {oReady, oValid, 32'(oData)}, {2'b10, 32'h0});

    // Flush coincident with read data: straight to IDLE
    iReq = 1'b1; ictrl = `DM_LB; iAddr = 32'h2001;
    step(); iReq = 1'b0;
    iMemAck = 1'b1;
    step(); iFlush = 1'b1; iMemRValid = 1'b1; iMemRData = 32'h11223344;
    step(); iFlush = 1'b0;
    chk("flush_rvalid_idle", {oReady, oValid, oBusy}, 3'b100);

    // Flush in REQ without ack: request drops next cycle
    iReq = 1'b1; ictrl = `DM_LH; iAddr = 32'h2002;
    step(); iReq = 1'b0;
    chk("req_asserted", oMemReq, 1'b1);
    iFlush = 1'b1;
    step(); iFlush = 1'b0;
    chk("flush_req_drop", {oMemReq, oReady}, 2'b01);

    // Flush in REQ with ack: must drain the outstanding read
    iReq = 1'b1; ictrl = `DM_LW; iAddr = 32'h2004;
    step(); iReq = 1'b0;
    iMemAck = 1'b1; iFlush = 1'b1;
    step(); iFlush = 1'b0;
    chk("flush_ack_drain", {oMemReq, oBusy, oValid}, 3'b010);
    iMemRValid = 1'b1;
    step();
    chk("flush_ack_idle", {oReady, oValid}, 2'b10);
    auto_mem = 1'b1;

    // Flush in RESP discards the result
    iReq = 1'b1; ictrl = `DM_LW; iAddr = 32'h0001;
    step(); iReq = 1'b0;
    chk("resp_adel", {oValid, oAdEL}, 2'b11);
    iFlush = 1'b1;
    step(); iFlush = 1'b0;
    chk("flush_resp", {oReady, oValid, oAdEL}, 3'b100);

    // Result held while iTake is withheld
    mem_word = 32'hBEEF0001; ack_dly = 1; rv_dly = 1; rv_cnt = -1; req_cnt = 0;
    iReq = 1'b1; ictrl = `DM_LHU; iAddr = 32'h3002;
    step(); iReq = 1'b0;
    n = 0;
    while (!oValid && n < 64) begin step(); n++; end
    chk("hold_reached", oValid, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("hold%0d", i), {oValid, oBusErr, oAdEL, 32'(oData)}, {3'b100, 32'h0000BEEF});
    end
    iTake = 1'b1;
    step(); iTake = 1'b0;
    chk("hold_taken", {oReady, oValid, 32'(oData)}, {2'b10, 32'h0});

    // Asynchronous reset in WAIT: outputs clear without a clock edge
    ack_dly = 0; rv_dly = -1; rv_cnt = -1; req_cnt = 0;
    iReq = 1'b1; ictrl = `DM_LW; iAddr = 32'h1234;
    step(); iReq = 1'b0;
    step();
    chk("wait_busy", {oBusy, oMemReq, 20'(oMemAddr)}, {2'b10, 20'h48D});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {26'd0, oReady, oBusy, oMemReq, oValid, oAdEL, oBusErr}, 32'h20);
    chk("async_rst_addr", 32'(oMemAddr), 32'h0);
    chk("async_rst_data", oData, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("post_reset_idle", {oReady, oBusy}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
